// File: rtl/id_ex_operand_stage_pkg.sv
// ----------------------------------------------------------------------------
// id_ex_operand_stage_pkg
// Shared constants and types for the ID/EX operand stage.
//   - CTRL_* : bit positions inside the 5-bit control bundle
//              {rf_we, mem_we, is_load, is_branch, is_jump}
//   - ASEL_* / BSEL_* : ALU operand source selects
//   - alu_op_e / wb_sel_e : ALU op codes and writeback-select encodings
//   - upd_e : what the ID/EX register does on the next edge
//   - fwd_hit() : "does this producer supply this source register"
// ----------------------------------------------------------------------------
package id_ex_operand_stage_pkg;

    localparam int CTRL_W   = 5;
    localparam int WB_SEL_W = 2;

    localparam int CTRL_IS_JUMP   = 0;
    localparam int CTRL_IS_BRANCH = 1;
    localparam int CTRL_IS_LOAD   = 2;
    localparam int CTRL_MEM_WE    = 3;
    localparam int CTRL_RF_WE     = 4;

    localparam logic ASEL_RS1 = 1'b0;
    localparam logic ASEL_PC  = 1'b1;
    localparam logic BSEL_RS2 = 1'b0;
    localparam logic BSEL_IMM = 1'b1;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'd0,
        WB_SEL_MEM = 2'd1,
        WB_SEL_PC4 = 2'd2
    } wb_sel_e;

    typedef enum logic [1:0] {
        UPD_CAPTURE = 2'd0,
        UPD_HOLD    = 2'd1,
        UPD_BUBBLE  = 2'd2
    } upd_e;

    // Register indices are passed zero-extended to 32 bits so the helper
    // works for any RA_W. x0 is hard-wired zero and is never a producer.
    function automatic logic fwd_hit(input logic        we,
                                     input logic [31:0] src_rd,
                                     input logic [31:0] rs);
        return we && (src_rd != 32'd0) && (src_rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// ----------------------------------------------------------------------------
// id_ex_operand_stage_fwd_mux
// Selects the freshest value of one source register for the EX stage.
// Ports:
//   en_i           forwarding enable; 0 passes raw_i straight through
//   rs_i           source register index held in ID/EX
//   raw_i          regfile data captured with the instruction
//   exmem_*_i      youngest producer (EX/MEM write-enable, rd, ALU result)
//   memwb_*_i      older producer (MEM/WB write-enable, rd, writeback data)
//   data_o         operand value
// ----------------------------------------------------------------------------
module id_ex_operand_stage_fwd_mux
    import id_ex_operand_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            en_i,
    input  logic [RA_W-1:0] rs_i,
    input  logic [XLEN-1:0] raw_i,
    input  logic            exmem_we_i,
    input  logic [RA_W-1:0] exmem_rd_i,
    input  logic [XLEN-1:0] exmem_res_i,
    input  logic            memwb_we_i,
    input  logic [RA_W-1:0] memwb_rd_i,
    input  logic [XLEN-1:0] memwb_wdata_i,
    output logic [XLEN-1:0] data_o
);

    always_comb begin
        data_o = raw_i;
        if (en_i) begin
            // EX/MEM is younger than MEM/WB, so it wins when both match.
            if (fwd_hit(exmem_we_i, 32'(exmem_rd_i), 32'(rs_i))) begin
                data_o = exmem_res_i;
            end else if (fwd_hit(memwb_we_i, 32'(memwb_rd_i), 32'(rs_i))) begin
                data_o = memwb_wdata_i;
            end
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ----------------------------------------------------------------------------
// id_ex_operand_stage
// ID/EX pipeline register with EX-side operand forwarding, load-use hazard
// detection, global stall and branch/jump flush.
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   stall_i, flush_i  global hold / kill of the instruction entering EX
//   id_*_i            decoded instruction and regfile read data
//   exmem_*_i         EX/MEM producer for forwarding
//   memwb_*_i         MEM/WB producer for forwarding
//   ld_use_stall_o    combinational; PC and IF/ID must hold this cycle
//   ex_*_o            registered EX slot and forwarded ALU operands
// ----------------------------------------------------------------------------
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RA_W    = 5,
    parameter int ALUOP_W = 4,
    parameter int FWD_EN  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic                id_valid_i,
    input  logic [XLEN-1:0]     id_pc_i,
    input  logic [RA_W-1:0]     id_rs1_i,
    input  logic [RA_W-1:0]     id_rs2_i,
    input  logic [RA_W-1:0]     id_rd_i,
    input  logic [XLEN-1:0]     id_rs1_data_i,
    input  logic [XLEN-1:0]     id_rs2_data_i,
    input  logic [XLEN-1:0]     id_imm_i,
    input  logic [ALUOP_W-1:0]  id_alu_op_i,
    input  logic                id_asel_i,
    input  logic                id_bsel_i,
    input  logic [CTRL_W-1:0]   id_ctrl_i,
    input  logic [WB_SEL_W-1:0] id_wb_sel_i,
    input  logic                exmem_rf_we_i,
    input  logic [RA_W-1:0]     exmem_rd_i,
    input  logic [XLEN-1:0]     exmem_res_i,
    input  logic                memwb_rf_we_i,
    input  logic [RA_W-1:0]     memwb_rd_i,
    input  logic [XLEN-1:0]     memwb_wdata_i,
    output logic                ld_use_stall_o,
    output logic                ex_valid_o,
    output logic [XLEN-1:0]     ex_pc_o,
    output logic [XLEN-1:0]     ex_alu_a_o,
    output logic [XLEN-1:0]     ex_alu_b_o,
    output logic [ALUOP_W-1:0]  ex_alu_op_o,
    output logic [XLEN-1:0]     ex_store_o,
    output logic [XLEN-1:0]     ex_imm_o,
    output logic [RA_W-1:0]     ex_rd_o,
    output logic [CTRL_W-1:0]   ex_ctrl_o,
    output logic [WB_SEL_W-1:0] ex_wb_sel_o
);

    // ID/EX register: index 0 = rs1 operand, index 1 = rs2 operand.
    logic                valid_q,   valid_d;
    logic [XLEN-1:0]     pc_q,      pc_d;
    logic [RA_W-1:0]     rs_q    [2];
    logic [RA_W-1:0]     rs_d    [2];
    logic [XLEN-1:0]     rdata_q [2];
    logic [XLEN-1:0]     rdata_d [2];
    logic [RA_W-1:0]     rd_q,      rd_d;
    logic [XLEN-1:0]     imm_q,     imm_d;
    logic [ALUOP_W-1:0]  alu_op_q,  alu_op_d;
    logic                asel_q,    asel_d;
    logic                bsel_q,    bsel_d;
    logic [CTRL_W-1:0]   ctrl_q,    ctrl_d;
    logic [WB_SEL_W-1:0] wb_sel_q,  wb_sel_d;

    logic [XLEN-1:0]     fwd_data [2];
    logic                ld_use;
    upd_e                upd;

    // A load still in EX cannot supply its data yet; the consumer in ID
    // waits one cycle so the load reaches MEM/WB. rs2 is matched even when
    // the consumer uses the immediate: conservative but harmless.
    assign ld_use = valid_q && ctrl_q[CTRL_IS_LOAD] && (rd_q != '0) &&
                    id_valid_i && ((rd_q == id_rs1_i) || (rd_q == id_rs2_i));
    assign ld_use_stall_o = ld_use;

    // Flush beats stall (the instruction is dead anyway); stall beats the
    // load-use bubble because ID is frozen too and nothing is lost.
    always_comb begin
        upd = UPD_CAPTURE;
        if (flush_i) begin
            upd = UPD_BUBBLE;
        end else if (stall_i) begin
            upd = UPD_HOLD;
        end else if (ld_use) begin
            upd = UPD_BUBBLE;
        end
    end

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs_d[0]    = rs_q[0];
        rs_d[1]    = rs_q[1];
        rdata_d[0] = rdata_q[0];
        rdata_d[1] = rdata_q[1];
        rd_d       = rd_q;
        imm_d      = imm_q;
        alu_op_d   = alu_op_q;
        asel_d     = asel_q;
        bsel_d     = bsel_q;
        ctrl_d     = ctrl_q;
        wb_sel_d   = wb_sel_q;
        case (upd)
            UPD_BUBBLE: begin
                valid_d    = 1'b0;
                pc_d       = '0;
                rs_d[0]    = '0;
                rs_d[1]    = '0;
                rdata_d[0] = '0;
                rdata_d[1] = '0;
                rd_d       = '0;
                imm_d      = '0;
                alu_op_d   = '0;
                asel_d     = 1'b0;
                bsel_d     = 1'b0;
                ctrl_d     = '0;
                wb_sel_d   = '0;
            end
            UPD_CAPTURE: begin
                valid_d    = id_valid_i;
                pc_d       = id_pc_i;
                rs_d[0]    = id_rs1_i;
                rs_d[1]    = id_rs2_i;
                rdata_d[0] = id_rs1_data_i;
                rdata_d[1] = id_rs2_data_i;
                rd_d       = id_rd_i;
                imm_d      = id_imm_i;
                alu_op_d   = id_alu_op_i;
                asel_d     = id_asel_i;
                bsel_d     = id_bsel_i;
                // An empty decode slot must never cause side effects.
                ctrl_d     = id_valid_i ? id_ctrl_i : '0;
                wb_sel_d   = id_wb_sel_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs_q[0]    <= '0;
            rs_q[1]    <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
            rd_q       <= '0;
            imm_q      <= '0;
            alu_op_q   <= '0;
            asel_q     <= 1'b0;
            bsel_q     <= 1'b0;
            ctrl_q     <= '0;
            wb_sel_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs_q[0]    <= rs_d[0];
            rs_q[1]    <= rs_d[1];
            rdata_q[0] <= rdata_d[0];
            rdata_q[1] <= rdata_d[1];
            rd_q       <= rd_d;
            imm_q      <= imm_d;
            alu_op_q   <= alu_op_d;
            asel_q     <= asel_d;
            bsel_q     <= bsel_d;
            ctrl_q     <= ctrl_d;
            wb_sel_q   <= wb_sel_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            id_ex_operand_stage_fwd_mux #(
                .XLEN (XLEN),
                .RA_W (RA_W)
            ) u_fwd_mux (
                .en_i          (FWD_EN != 0),
                .rs_i          (rs_q[gi]),
                .raw_i         (rdata_q[gi]),
                .exmem_we_i    (exmem_rf_we_i),
                .exmem_rd_i    (exmem_rd_i),
                .exmem_res_i   (exmem_res_i),
                .memwb_we_i    (memwb_rf_we_i),
                .memwb_rd_i    (memwb_rd_i),
                .memwb_wdata_i (memwb_wdata_i),
                .data_o        (fwd_data[gi])
            );
        end
    endgenerate

    assign ex_valid_o  = valid_q;
    assign ex_pc_o     = pc_q;
    assign ex_alu_a_o  = (asel_q == ASEL_PC)  ? pc_q  : fwd_data[0];
    assign ex_alu_b_o  = (bsel_q == BSEL_IMM) ? imm_q : fwd_data[1];
    assign ex_alu_op_o = alu_op_q;
    assign ex_store_o  = fwd_data[1];
    assign ex_imm_o    = imm_q;
    assign ex_rd_o     = rd_q;
    assign ex_ctrl_o   = ctrl_q;
    assign ex_wb_sel_o = wb_sel_q;

endmodule
